// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file write-back front end.
//   NUM_SRC_DEFAULT   default number of write-back producers
//   SRC_ALU/LSU/MUL   conventional producer slot indices
//   MAX_ADDR_WIDTH    widest register address the helpers handle
//   ext_addr_c()      widens a port C read address, filling the upper bits with ones
package regfile_wb_pkg;

  localparam int NUM_SRC_DEFAULT = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_MUL = 2;

  localparam int MAX_ADDR_WIDTH = 16;

  // Port C only reaches the top slice of the register file, so every bit
  // at or above width_c is implied to be one.
  function automatic logic [MAX_ADDR_WIDTH-1:0] ext_addr_c(
    input logic [MAX_ADDR_WIDTH-1:0] addr_c,
    input int                        width_c
  );
    logic [MAX_ADDR_WIDTH-1:0] res;
    res = addr_c;
    for (int i = 0; i < MAX_ADDR_WIDTH; i++) begin
      if (i >= width_c) res[i] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational two-winner round-robin picker.
//   pending     per-source request pending
//   addr        per-source destination address
//   rr_ptr      current round-robin start position
//   grant_a     one-hot winner for write port A (first pending at/after rr_ptr)
//   grant_b     one-hot winner for write port B (next pending after A whose
//               address differs from A's)
//   rr_ptr_nxt  one past the last winner (B if any, else A); rr_ptr when idle
module wb_rr_pick2 #(
  parameter int NUM_SRC    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int PTR_W      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]                 pending,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] addr,
  input  logic [PTR_W-1:0]                   rr_ptr,
  output logic [NUM_SRC-1:0]                 grant_a,
  output logic [NUM_SRC-1:0]                 grant_b,
  output logic [PTR_W-1:0]                   rr_ptr_nxt
);

  // base + k modulo NUM_SRC; both operands are below NUM_SRC, so a single
  // conditional subtract wraps correctly even when NUM_SRC is not 2^n.
  function automatic logic [PTR_W-1:0] wrap_add(
    input logic [PTR_W-1:0] base,
    input int               k
  );
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(k);
    if (sum >= (PTR_W+1)'(NUM_SRC)) sum = sum - (PTR_W+1)'(NUM_SRC);
    return sum[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0] a_idx;
  logic [PTR_W-1:0] b_idx;
  logic             a_found;
  logic             b_found;

  always_comb begin
    logic [PTR_W-1:0] idx;
    a_idx   = '0;
    b_idx   = '0;
    a_found = 1'b0;
    b_found = 1'b0;
    idx     = '0;

    for (int k = 0; k < NUM_SRC; k++) begin
      idx = wrap_add(rr_ptr, k);
      if (!a_found && pending[idx]) begin
        a_found = 1'b1;
        a_idx   = idx;
      end
    end

    // A candidate sharing A's address is skipped; it stays pending and
    // goes out in a later cycle, so the two ports never collide.
    for (int k = 1; k < NUM_SRC; k++) begin
      idx = wrap_add(a_idx, k);
      if (a_found && !b_found && pending[idx] && (addr[idx] != addr[a_idx])) begin
        b_found = 1'b1;
        b_idx   = idx;
      end
    end
  end

  always_comb begin
    grant_a    = '0;
    grant_b    = '0;
    rr_ptr_nxt = rr_ptr;
    if (a_found) grant_a[a_idx] = 1'b1;
    if (b_found) grant_b[b_idx] = 1'b1;
    if (b_found)      rr_ptr_nxt = wrap_add(b_idx, 1);
    else if (a_found) rr_ptr_nxt = wrap_add(a_idx, 1);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back front end for the 3-read/2-write latch register file.
//   clk, rst_n                      clock, asynchronous active-low reset
//   src_valid_i/src_ready_o         per-producer write request handshake
//   src_addr_i/src_data_i           per-producer destination and data
//   we_a_o/waddr_a_o/wdata_a_o      register-file write port A
//   we_b_o/waddr_b_o/wdata_b_o      register-file write port B
//   raddr_a_i/raddr_b_i/raddr_c_i   read addresses seen by the register file
//   rf_rdata_{a,b,c}_i              raw register-file read data
//   rdata_{a,b,c}_o                 read data corrected for last cycle's writes
//
// Handshake: a request transfers on a rising edge where src_valid_i[s] and
// src_ready_o[s] are both high. The producer must hold valid/addr/data
// stable until that edge. Ready depends only on the holding register and
// this cycle's grant, never on src_valid_i.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int ADDR_WIDTH_C = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_SRC      = NUM_SRC_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_data_i,
  output logic                                we_a_o,
  output logic [ADDR_WIDTH-1:0]               waddr_a_o,
  output logic [DATA_WIDTH-1:0]               wdata_a_o,
  output logic                                we_b_o,
  output logic [ADDR_WIDTH-1:0]               waddr_b_o,
  output logic [DATA_WIDTH-1:0]               wdata_b_o,
  input  logic [ADDR_WIDTH-1:0]               raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]               raddr_b_i,
  input  logic [ADDR_WIDTH_C-1:0]             raddr_c_i,
  input  logic [DATA_WIDTH-1:0]               rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0]               rf_rdata_b_i,
  input  logic [DATA_WIDTH-1:0]               rf_rdata_c_i,
  output logic [DATA_WIDTH-1:0]               rdata_a_o,
  output logic [DATA_WIDTH-1:0]               rdata_b_o,
  output logic [DATA_WIDTH-1:0]               rdata_c_o
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                 hold_valid;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] hold_addr;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] hold_data;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [NUM_SRC-1:0] grant_a;
  logic [NUM_SRC-1:0] grant_b;
  logic [NUM_SRC-1:0] grant;

  logic                  fwd_a_valid;
  logic [ADDR_WIDTH-1:0] fwd_a_addr;
  logic [DATA_WIDTH-1:0] fwd_a_data;
  logic                  fwd_b_valid;
  logic [ADDR_WIDTH-1:0] fwd_b_addr;
  logic [DATA_WIDTH-1:0] fwd_b_data;

  logic [ADDR_WIDTH-1:0] raddr_c_ext;

  // Arbitration sees only registered state, so no path exists from src_*
  // to the write ports.
  wb_rr_pick2 #(
    .NUM_SRC    (NUM_SRC),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_W      (PTR_W)
  ) u_pick (
    .pending    (hold_valid),
    .addr       (hold_addr),
    .rr_ptr     (rr_ptr),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .rr_ptr_nxt (rr_ptr_nxt)
  );

  assign grant       = grant_a | grant_b;
  // A granted entry leaves this edge, so the slot can reload at once.
  assign src_ready_o = ~hold_valid | grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
      rr_ptr     <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (src_valid_i[s] && src_ready_o[s]) begin
          hold_valid[s] <= 1'b1;
          hold_addr[s]  <= src_addr_i[s];
          hold_data[s]  <= src_data_i[s];
        end else if (grant[s]) begin
          hold_valid[s] <= 1'b0;
        end
      end
    end
  end

  // Grants are one-hot, so OR-ing the selected entries is a clean mux and
  // an idle port naturally drives zeros.
  always_comb begin
    waddr_a_o = '0;
    wdata_a_o = '0;
    waddr_b_o = '0;
    wdata_b_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant_a[s]) begin
        waddr_a_o = waddr_a_o | hold_addr[s];
        wdata_a_o = wdata_a_o | hold_data[s];
      end
      if (grant_b[s]) begin
        waddr_b_o = waddr_b_o | hold_addr[s];
        wdata_b_o = wdata_b_o | hold_data[s];
      end
    end
  end

  assign we_a_o = |grant_a;
  assign we_b_o = |grant_b;

  // The latch array shows a write one cycle late; these registers carry
  // that cycle's writes so reads see them in the meantime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_valid <= 1'b0;
      fwd_a_addr  <= '0;
      fwd_a_data  <= '0;
      fwd_b_valid <= 1'b0;
      fwd_b_addr  <= '0;
      fwd_b_data  <= '0;
    end else begin
      fwd_a_valid <= we_a_o;
      fwd_a_addr  <= waddr_a_o;
      fwd_a_data  <= wdata_a_o;
      fwd_b_valid <= we_b_o;
      fwd_b_addr  <= waddr_b_o;
      fwd_b_data  <= wdata_b_o;
    end
  end

  // ADDR_WIDTH must not exceed MAX_ADDR_WIDTH for this widening.
  assign raddr_c_ext = ADDR_WIDTH'(ext_addr_c(MAX_ADDR_WIDTH'(raddr_c_i), ADDR_WIDTH_C));

  // The ports never carry the same address, so B-before-A only breaks a
  // tie that cannot occur. Same-cycle writes are not forwarded.
  assign rdata_a_o = (fwd_b_valid && (fwd_b_addr == raddr_a_i))   ? fwd_b_data :
                     (fwd_a_valid && (fwd_a_addr == raddr_a_i))   ? fwd_a_data :
                                                                    rf_rdata_a_i;
  assign rdata_b_o = (fwd_b_valid && (fwd_b_addr == raddr_b_i))   ? fwd_b_data :
                     (fwd_a_valid && (fwd_a_addr == raddr_b_i))   ? fwd_a_data :
                                                                    rf_rdata_b_i;
  assign rdata_c_o = (fwd_b_valid && (fwd_b_addr == raddr_c_ext)) ? fwd_b_data :
                     (fwd_a_valid && (fwd_a_addr == raddr_c_ext)) ? fwd_a_data :
                                                                    rf_rdata_c_i;

endmodule
